// File: rtl/exec_block_pipe.sv
`default_nettype none
// ============================================================================
// Module  : exec_block_pipe
// Brief   : 2-stage (EX/WB) execution block: register file, B-operand mux,
//           immediate extender, ALU and write-back mux with EX->read forwarding.
//           Define EXEC_MUL_EN to build in the multi-cycle shift-add multiplier.
// Revision: 1.0
// ============================================================================
module exec_block_pipe #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*REG_AW-1:0]   instruction,
  input  logic [DATA_W-1:0]     dataInReg,
  input  logic [4:0]            opALU,
  input  logic [1:0]            selB,
  input  logic                  selAw,
  input  logic                  selD,
  input  logic                  wR,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     outALU,
  output logic [DATA_W-1:0]     dataOutReg,
  output logic [DATA_W-1:0]     label,
  output logic                  CO,
  output logic                  OV,
  output logic                  Z
);

  localparam int         c_IMM_W  = 2 * REG_AW;
  localparam int         c_NREG   = 2 ** REG_AW;
  localparam logic [4:0] c_OP_ADD = 5'd0;
  localparam logic [4:0] c_OP_SUB = 5'd1;
  localparam logic [4:0] c_OP_AND = 5'd2;
  localparam logic [4:0] c_OP_OR  = 5'd3;
  localparam logic [4:0] c_OP_XOR = 5'd4;
  localparam logic [4:0] c_OP_SLL = 5'd5;
  localparam logic [4:0] c_OP_MUL = 5'd16;

  logic [DATA_W-1:0]        r_regs [c_NREG];

  logic                     r_exValid;
  logic [DATA_W-1:0]        r_exA, r_exB, r_exQB, r_exDin;
  logic [c_IMM_W-1:0]       r_exImm;
  logic [4:0]               r_exOp;
  logic                     r_exSelD, r_exWR;
  logic [REG_AW-1:0]        r_exWAddr;

  logic                     r_outValid, r_co, r_ov, r_z;
  logic [DATA_W-1:0]        r_outALU, r_dataOut, r_label;

  logic [REG_AW-1:0]        w_aRA, w_aRB, w_aRW, w_wAddr;
  logic [c_IMM_W-1:0]       w_imm;
  logic signed [c_IMM_W-1:0] w_immS;
  logic [DATA_W-1:0]        w_qA, w_qB, w_opB, w_wbData;
  logic                     w_accept, w_exAdvance, w_fwdEn;
  logic [DATA_W:0]          w_sum;
  logic [DATA_W-1:0]        w_f;
  logic                     w_co, w_ov, w_z;

  assign w_aRA   = instruction[4*REG_AW-1:3*REG_AW];
  assign w_aRB   = instruction[3*REG_AW-1:2*REG_AW];
  assign w_aRW   = instruction[2*REG_AW-1:REG_AW];
  assign w_imm   = instruction[c_IMM_W-1:0];
  assign w_immS  = w_imm;
  assign w_wAddr = selAw ? w_aRW : w_aRB;
  assign w_accept = in_valid & in_ready;

  // The EX instruction retires on the same edge the new one is read, so its
  // write data bypasses the register file.
  assign w_wbData = r_exSelD ? w_f : r_exDin;
  assign w_fwdEn  = r_exValid & r_exWR & w_exAdvance;
  assign w_qA = (w_fwdEn && (r_exWAddr == w_aRA)) ? w_wbData : r_regs[w_aRA];
  assign w_qB = (w_fwdEn && (r_exWAddr == w_aRB)) ? w_wbData : r_regs[w_aRB];

  always_comb begin
    w_opB = '0;
    case (selB)
      2'd1:    w_opB = w_qB;
      2'd2:    w_opB = DATA_W'(w_imm);
      2'd3:    w_opB = DATA_W'(w_immS);
      default: w_opB = '0;
    endcase
  end

`ifdef EXEC_MUL_EN
  localparam int c_CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   r_state, w_stateNext;
  logic [2*DATA_W-1:0]      r_mulAcc, r_mulMcand;
  logic [DATA_W-1:0]        r_mulMplier;
  logic [c_CNT_W-1:0]       r_mulCnt;
  logic                     w_mulIssue;

  assign w_mulIssue  = w_accept && (opALU == c_OP_MUL);
  assign in_ready    = (r_state != S_MUL);
  assign w_exAdvance = (r_state != S_MUL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE:  if (w_mulIssue) w_stateNext = S_MUL;
      S_MUL:   if (r_mulCnt == c_CNT_W'(DATA_W - 1)) w_stateNext = S_DONE;
      S_DONE:  w_stateNext = w_mulIssue ? S_MUL : S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Operands are captured at issue so the first shift-add step happens on the next edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mulAcc    <= '0;
      r_mulMcand  <= '0;
      r_mulMplier <= '0;
      r_mulCnt    <= '0;
    end else if (w_mulIssue) begin
      r_mulAcc    <= '0;
      r_mulMcand  <= {{DATA_W{1'b0}}, w_qA};
      r_mulMplier <= w_opB;
      r_mulCnt    <= '0;
    end else if (r_state == S_MUL) begin
      if (r_mulMplier[0]) r_mulAcc <= r_mulAcc + r_mulMcand;
      r_mulMcand  <= r_mulMcand << 1;
      r_mulMplier <= r_mulMplier >> 1;
      r_mulCnt    <= r_mulCnt + 1'b1;
    end
  end
`else
  assign in_ready    = 1'b1;
  assign w_exAdvance = 1'b1;
`endif

  always_comb begin
    w_sum = '0;
    w_f   = r_exA;
    w_co  = 1'b0;
    w_ov  = 1'b0;
    case (r_exOp)
      c_OP_ADD: begin
        w_sum = {1'b0, r_exA} + {1'b0, r_exB};
        w_f   = w_sum[DATA_W-1:0];
        w_co  = w_sum[DATA_W];
        w_ov  = (r_exA[DATA_W-1] == r_exB[DATA_W-1]) && (w_f[DATA_W-1] != r_exA[DATA_W-1]);
      end
      c_OP_SUB: begin
        w_sum = {1'b0, r_exA} + {1'b0, ~r_exB} + {{DATA_W{1'b0}}, 1'b1};
        w_f   = w_sum[DATA_W-1:0];
        w_co  = w_sum[DATA_W];
        w_ov  = (r_exA[DATA_W-1] != r_exB[DATA_W-1]) && (w_f[DATA_W-1] != r_exA[DATA_W-1]);
      end
      c_OP_AND: w_f = r_exA & r_exB;
      c_OP_OR:  w_f = r_exA | r_exB;
      c_OP_XOR: w_f = r_exA ^ r_exB;
      c_OP_SLL: w_f = r_exA << r_exB[2:0];
      c_OP_MUL: begin
`ifdef EXEC_MUL_EN
        w_f  = r_mulAcc[DATA_W-1:0];
        w_co = |r_mulAcc[2*DATA_W-1:DATA_W];
`else
        w_f  = '0;
`endif
      end
      default:  w_f = r_exA;
    endcase
    w_z = (w_f == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < c_NREG; i++) r_regs[i] <= '0;
      r_exValid  <= 1'b0;
      r_exA      <= '0;
      r_exB      <= '0;
      r_exQB     <= '0;
      r_exDin    <= '0;
      r_exImm    <= '0;
      r_exOp     <= '0;
      r_exSelD   <= 1'b0;
      r_exWR     <= 1'b0;
      r_exWAddr  <= '0;
      r_outValid <= 1'b0;
      r_outALU   <= '0;
      r_dataOut  <= '0;
      r_label    <= '0;
      r_co       <= 1'b0;
      r_ov       <= 1'b0;
      r_z        <= 1'b0;
    end else if (w_exAdvance) begin
      r_exValid  <= w_accept;
      if (w_accept) begin
        r_exA     <= w_qA;
        r_exB     <= w_opB;
        r_exQB    <= w_qB;
        r_exDin   <= dataInReg;
        r_exImm   <= w_imm;
        r_exOp    <= opALU;
        r_exSelD  <= selD;
        r_exWR    <= wR;
        r_exWAddr <= w_wAddr;
      end
      r_outValid <= r_exValid;
      if (r_exValid) begin
        r_outALU  <= w_f;
        r_co      <= w_co;
        r_ov      <= w_ov;
        r_z       <= w_z;
        r_dataOut <= r_exQB;
        r_label   <= DATA_W'(r_exImm);
        if (r_exWR) r_regs[r_exWAddr] <= w_wbData;
      end
    end else begin
      r_outValid <= 1'b0;
    end
  end

  assign out_valid  = r_outValid;
  assign outALU     = r_outALU;
  assign dataOutReg = r_dataOut;
  assign label      = r_label;
  assign CO         = r_co;
  assign OV         = r_ov;
  assign Z          = r_z;

endmodule
`default_nettype wire

// File: tb/tb_exec_block_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_exec_block_pipe
// Brief   : Scoreboard bench for exec_block_pipe (DATA_W=8, REG_AW=3).
// Revision: 1.0
// ============================================================================
module tb_exec_block_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] instruction;
  logic [7:0]  dataInReg;
  logic [4:0]  opALU;
  logic [1:0]  selB;
  logic        selAw, selD, wR, in_valid;
  logic        in_ready, out_valid, CO, OV, Z;
  logic [7:0]  outALU, dataOutReg, label;

  typedef struct packed {
    logic [7:0] f;
    logic [7:0] qb;
    logic [7:0] lbl;
    logic       co;
    logic       ov;
    logic       z;
  } exp_t;

  exp_t       expQ[$];
  exp_t       monE;
  logic [7:0] mrf [8];
  int         checks   = 0;
  int         failures = 0;

  exec_block_pipe #(.DATA_W(8), .REG_AW(3)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .dataInReg(dataInReg),
    .opALU(opALU), .selB(selB), .selAw(selAw), .selD(selD), .wR(wR),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
    .outALU(outALU), .dataOutReg(dataOutReg), .label(label),
    .CO(CO), .OV(OV), .Z(Z)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer
  always @(negedge clk) begin
    if (rst && out_valid) begin
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out_valid got=1 want=0");
      end else begin
        monE = expQ.pop_front();
        if ({outALU, dataOutReg, label, CO, OV, Z} !== monE) begin
          failures++;
          $display("FAIL scoreboard got=%h want=%h", {outALU, dataOutReg, label, CO, OV, Z}, monE);
        end
      end
    end
  end

  function automatic exp_t model(input logic [11:0] ins, input logic [7:0] din,
                                 input logic [4:0] op, input logic [1:0] sb,
                                 input logic saw, input logic sd, input logic we);
    logic [7:0]  a, b, qb, f;
    logic [5:0]  imm;
    logic [15:0] p;
    logic        co, ov;
    int          us, ss;
    exp_t        e;
    a   = mrf[ins[11:9]];
    qb  = mrf[ins[8:6]];
    imm = ins[5:0];
    case (sb)
      2'd0:    b = 8'h00;
      2'd1:    b = qb;
      2'd2:    b = {2'b00, imm};
      default: b = {{2{imm[5]}}, imm};
    endcase
    co = 1'b0;
    ov = 1'b0;
    p  = 16'h0;
    case (op)
      5'd0: begin
        us = int'(a) + int'(b);
        ss = int'($signed(a)) + int'($signed(b));
        f  = us[7:0];
        co = (us > 255);
        ov = (ss > 127) || (ss < -128);
      end
      5'd1: begin
        ss = int'($signed(a)) - int'($signed(b));
        f  = a - b;
        co = (a >= b);
        ov = (ss > 127) || (ss < -128);
      end
      5'd2:  f = a & b;
      5'd3:  f = a | b;
      5'd4:  f = a ^ b;
      5'd5:  f = a << b[2:0];
      5'd16: begin
`ifdef EXEC_MUL_EN
        p  = 16'(a) * 16'(b);
        f  = p[7:0];
        co = (p[15:8] != 8'h00);
`else
        f  = 8'h00;
`endif
      end
      default: f = a;
    endcase
    e = '{f: f, qb: qb, lbl: {2'b00, imm}, co: co, ov: ov, z: (f == 8'h00)};
    if (we) mrf[saw ? ins[5:3] : ins[8:6]] = sd ? f : din;
    return e;
  endfunction

  // Starts between negedge and posedge; returns at the negedge after acceptance.
  task automatic issue(input logic [11:0] ins, input logic [7:0] din, input logic [4:0] op,
                       input logic [1:0] sb, input logic saw, input logic sd, input logic we);
    int n;
    expQ.push_back(model(ins, din, op, sb, saw, sd, we));
    instruction = ins; dataInReg = din; opALU = op; selB = sb;
    selAw = saw; selD = sd; wR = we; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL issue_timeout got=%0d want<200", n);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout got=%0d want=0 pending", expQ.size());
    end
  endtask

  task automatic readReg(input logic [2:0] r);
    issue({r, 9'd0}, 8'h00, 5'd7, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({outALU, dataOutReg, label, CO, OV, Z, out_valid, in_ready} !== {24'h0, 4'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_state got=%h want=%h",
               {outALU, dataOutReg, label, CO, OV, Z, out_valid, in_ready}, {24'h0, 4'b0, 1'b1});
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load();
    issue({3'd0, 3'd0, 3'd1, 3'd0}, 8'h7F, 5'd7, 2'd0, 1'b1, 1'b0, 1'b1);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL load_latency_early got=%b want=0", out_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL load_latency got=%b want=1", out_valid);
    end
    drain();
    readReg(3'd1);
    drain();
    checks++;
    if (outALU !== 8'h7F) begin
      failures++;
      $display("FAIL load_r1 got=%h want=7f", outALU);
    end
  endtask

  task automatic test_add_forward();
    issue({3'd1, 3'd2, 6'h01}, 8'h00, 5'd0, 2'd3, 1'b0, 1'b1, 1'b1);
    issue({3'd2, 3'd2, 3'd3, 3'd0}, 8'h00, 5'd0, 2'd1, 1'b1, 1'b1, 1'b1);
    #1;
    checks++;
    if ({out_valid, outALU, CO, OV, Z} !== {1'b1, 8'h80, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL add_sext got=%h want=%h", {out_valid, outALU, CO, OV, Z}, {1'b1, 8'h80, 3'b010});
    end
    @(negedge clk);
    #1;
    checks++;
    if ({out_valid, outALU, CO, OV, Z} !== {1'b1, 8'h00, 1'b1, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL add_forward got=%h want=%h", {out_valid, outALU, CO, OV, Z}, {1'b1, 8'h00, 3'b111});
    end
    drain();
  endtask

  task automatic test_sub_and();
    issue({3'd1, 3'd1, 6'h00}, 8'h00, 5'd1, 2'd1, 1'b0, 1'b1, 1'b0);
    issue({3'd1, 3'd0, 6'h00}, 8'h00, 5'd2, 2'd0, 1'b0, 1'b1, 1'b0);
    #1;
    checks++;
    if ({outALU, CO, OV, Z} !== {8'h00, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL sub_equal got=%h want=%h", {outALU, CO, OV, Z}, {8'h00, 3'b101});
    end
    @(negedge clk);
    #1;
    checks++;
    if ({outALU, Z} !== {8'h00, 1'b1}) begin
      failures++;
      $display("FAIL and_zero got=%h want=%h", {outALU, Z}, {8'h00, 1'b1});
    end
    drain();
  endtask

  task automatic test_mul();
    int n;
    issue({3'd0, 3'd0, 3'd4, 3'd0}, 8'h10, 5'd7, 2'd0, 1'b1, 1'b0, 1'b1);
    issue({3'd4, 3'd0, 6'h11}, 8'h00, 5'd16, 2'd2, 1'b1, 1'b1, 1'b1);
`ifdef EXEC_MUL_EN
    n = 0;
    while (!in_ready && n < 20) begin
      if (n == 0) begin
        instruction = {3'd0, 3'd0, 3'd5, 3'd0}; dataInReg = 8'hAA; opALU = 5'd7;
        selB = 2'd0; selAw = 1'b1; selD = 1'b0; wR = 1'b1; in_valid = 1'b1;
      end
      if (n == 3) in_valid = 1'b0;
      n++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (n !== 8) begin
      failures++;
      $display("FAIL mul_busy_cycles got=%0d want=8", n);
    end
    drain();
    checks++;
    if ({outALU, CO, OV, Z} !== {8'h10, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL mul_result got=%h want=%h", {outALU, CO, OV, Z}, {8'h10, 3'b100});
    end
`else
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mul_ready got=%b want=1", in_ready);
    end
    drain();
    checks++;
    if ({outALU, CO, OV, Z} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL mul_disabled got=%h want=%h", {outALU, CO, OV, Z}, {8'h00, 3'b001});
    end
`endif
    readReg(3'd5);
    readReg(3'd2);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [4:0] opl [9];
    opl = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd7, 5'd9, 5'd16};
    for (int i = 0; i < 40; i++) begin
      issue(12'($urandom), 8'($urandom), opl[$urandom_range(0, 8)], 2'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom));
    end
    drain();
  endtask

  task automatic test_bubble();
    int pulses;
    issue({3'd1, 3'd1, 6'h05}, 8'h00, 5'd3, 2'd2, 1'b0, 1'b1, 1'b0);
    pulses = 0;
    repeat (5) begin
      #1;
      if (out_valid) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses !== 1) begin
      failures++;
      $display("FAIL bubble_pulses got=%0d want=1", pulses);
    end
    drain();
  endtask

  task automatic test_reset_mid_mul();
    int spurious;
    issue({3'd1, 3'd1, 3'd6, 3'd0}, 8'h00, 5'd16, 2'd1, 1'b1, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({outALU, dataOutReg, label, CO, OV, Z, out_valid, in_ready} !== {24'h0, 4'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_mid_mul got=%h want=%h",
               {outALU, dataOutReg, label, CO, OV, Z, out_valid, in_ready}, {24'h0, 4'b0, 1'b1});
    end
    expQ.delete();
    for (int i = 0; i < 8; i++) mrf[i] = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    spurious = 0;
    repeat (12) begin
      @(negedge clk);
      #1;
      if (out_valid) spurious++;
    end
    checks++;
    if (spurious !== 0) begin
      failures++;
      $display("FAIL reset_abort_out_valid got=%0d want=0", spurious);
    end
    for (int r = 1; r < 8; r++) begin
      readReg(3'(r));
      drain();
      checks++;
      if (outALU !== 8'h00) begin
        failures++;
        $display("FAIL reset_reg_r%0d got=%h want=00", r, outALU);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) mrf[i] = 8'h00;
    rst = 1'b0; instruction = '0; dataInReg = '0; opALU = '0; selB = '0;
    selAw = 1'b0; selD = 1'b0; wR = 1'b0; in_valid = 1'b0;
    test_reset();
    test_load();
    test_add_forward();
    test_sub_and();
    test_mul();
    test_back_to_back();
    test_bubble();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
